uart_rx_fifo: RTL and testbench

//  UART receiver with 16x oversampling and a byte FIFO. It sits upstream of the housekeeping CPU's

---
 rtl/uart_rx_fifo.sv | 137 +++++++++++++
 tb/tb_uart_rx_fifo.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, 16x oversampling) feeding a 2**ADDR_W-byte FIFO.
// Sticky overrun/framing flags; one pop per rising edge of the read level.
module uart_rx_fifo #(
  parameter int ADDR_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baudclk16,
  input  logic       rx,
  output logic [7:0] data,
  output logic       ready,
  input  logic       read,
  input  logic       clear_errors,
  output logic       overrun,
  output logic       framing_error
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] PTR_ONE = 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state;
  logic              rx_m, rx_s, read_q;
  logic [3:0]        tick;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr, rd_ptr;
  logic              push, frame_err, full, empty, pop, wr_en;

  // Stop-bit decision is taken combinationally so the push lands in the sample clk.
  always_comb begin
    push      = 1'b0;
    frame_err = 1'b0;
    if (baudclk16 && state == STOP && tick == 4'd15) begin
      push      = rx_s;
      frame_err = ~rx_s;
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign pop   = read & ~read_q & ~empty;
  assign wr_en = push & (~full | pop);
  assign ready = ~empty;
  assign data  = mem[rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m   <= 1'b1;
      rx_s   <= 1'b1;
      read_q <= 1'b0;
    end else begin
      rx_m   <= rx;
      rx_s   <= rx_m;
      read_q <= read;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tick    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else if (baudclk16) begin
      case (state)
        IDLE: begin
          tick <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (tick == 4'd7) begin
            tick <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            tick <= tick + 4'd1;
          end
        end
        DATA: begin
          if (tick == 4'd15) begin
            tick  <= '0;
            shreg <= {rx_s, shreg[7:1]};
            if (bit_idx == 3'd7) state <= STOP;
            else bit_idx <= bit_idx + 3'd1;
          end else begin
            tick <= tick + 4'd1;
          end
        end
        STOP: begin
          if (tick == 4'd15) begin
            tick  <= '0;
            state <= IDLE;
          end else begin
            tick <= tick + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory is reset so that data reads 0 while the FIFO is empty after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[ADDR_W-1:0]] <= shreg;
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun       <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      if (push && full && !pop) overrun <= 1'b1;
      else if (clear_errors)     overrun <= 1'b0;
      if (frame_err)             framing_error <= 1'b1;
      else if (clear_errors)     framing_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: 8N1 frames at 336 clk/bit, baudclk16 one clk in 21.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       baudclk16 = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       read = 1'b0;
  logic       clear_errors = 1'b0;
  logic       overrun;
  logic       framing_error;

  int checks = 0;
  int errors = 0;
  int bcnt = 0;

  uart_rx_fifo #(.ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .baudclk16(baudclk16), .rx(rx),
    .data(data), .ready(ready), .read(read), .clear_errors(clear_errors),
    .overrun(overrun), .framing_error(framing_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bcnt == 20) bcnt <= 0;
    else bcnt <= bcnt + 1;
    baudclk16 <= (bcnt == 20);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [7:0] v;
    v = b;
    rx = 1'b0;
    wait_clks(336);
    for (int i = 0; i < 8; i++) begin
      rx = v[i];
      wait_clks(336);
    end
    rx = stop;
    wait_clks(336);
    rx = 1'b1;
  endtask

  task automatic pop_byte();
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear_errors = 1'b1;
    @(negedge clk);
    clear_errors = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic seen;
    logic [7:0] b;

    // Reset state
    wait_clks(3);
    check("rst_ready", ready, 1'b0);
    check("rst_data", data, 8'h00);
    check("rst_overrun", overrun, 1'b0);
    check("rst_ferr", framing_error, 1'b0);
    reset = 1'b0;
    wait_clks(50);

    // 1: single valid frame
    send_byte(8'hA5, 1'b1);
    check("t1_ready", ready, 1'b1);
    check("t1_data", data, 8'hA5);
    check("t1_overrun", overrun, 1'b0);
    check("t1_ferr", framing_error, 1'b0);
    pop_byte();
    check("t1_empty", ready, 1'b0);

    // 2: short low glitch is rejected
    rx = 1'b0;
    wait_clks(84);
    rx = 1'b1;
    wait_clks(400);
    check("t2_ready", ready, 1'b0);
    check("t2_ferr", framing_error, 1'b0);
    check("t2_overrun", overrun, 1'b0);

    // 3: bad stop bit, then good frame
    send_byte(8'h3C, 1'b0);
    wait_clks(672);
    check("t3_ferr_set", framing_error, 1'b1);
    check("t3_no_push", ready, 1'b0);
    send_byte(8'h5A, 1'b1);
    check("t3_ready", ready, 1'b1);
    check("t3_data", data, 8'h5A);
    check("t3_ferr_sticky", framing_error, 1'b1);
    pop_byte();
    check("t3_only_one", ready, 1'b0);
    pulse_clear();
    check("t3_ferr_clr", framing_error, 1'b0);

    // 4: 17 bytes into a 16-deep FIFO
    for (int i = 0; i < 17; i++) begin
      b = 8'(i);
      send_byte(b, 1'b1);
    end
    check("t4_overrun", overrun, 1'b1);
    check("t4_head", data, 8'h00);
    check("t4_ferr", framing_error, 1'b0);
    pulse_clear();
    check("t4_ov_clr", overrun, 1'b0);

    // Push and pop in the same clk while full
    seen = 1'b0;
    fork
      send_byte(8'h11, 1'b1);
      begin
        for (int k = 0; k < 5000 && !seen; k++) begin
          @(negedge clk);
          if (dut.push) begin
            read = 1'b1;
            seen = 1'b1;
          end
        end
        @(negedge clk);
        read = 1'b0;
      end
    join
    check("t4_push_seen", seen, 1'b1);
    check("t4_full_no_ov", overrun, 1'b0);
    check("t4_head_after", data, 8'h01);
    for (int i = 1; i <= 13; i++) begin
      check($sformatf("t4_rd%0d", i), data, 32'(i));
      pop_byte();
    end

    // 5: level read gives one pop (queue holds 0E, 0F, 11)
    check("t5_head", data, 8'h0E);
    read = 1'b1;
    wait_clks(100);
    check("t5_one_pop", data, 8'h0F);
    check("t5_ready", ready, 1'b1);
    read = 1'b0;
    @(negedge clk);
    pop_byte();
    check("t5_last", data, 8'h11);
    pop_byte();
    check("t5_empty", ready, 1'b0);
    read = 1'b1;
    wait_clks(5);
    check("t5_empty_edge", ready, 1'b0);
    send_byte(8'h77, 1'b1);
    check("t5_not_remembered", ready, 1'b1);
    check("t5_data77", data, 8'h77);
    read = 1'b0;
    @(negedge clk);

    // 6: reset mid-DATA with a byte still queued
    rx = 1'b0;
    wait_clks(336);
    rx = 1'b1;
    wait_clks(336);
    rx = 1'b0;
    wait_clks(500);
    reset = 1'b1;
    wait_clks(3);
    rx = 1'b1;
    reset = 1'b0;
    wait_clks(400);
    check("t6_ready", ready, 1'b0);
    check("t6_data", data, 8'h00);
    check("t6_overrun", overrun, 1'b0);
    check("t6_ferr", framing_error, 1'b0);
    send_byte(8'h81, 1'b1);
    check("t6_rx_ready", ready, 1'b1);
    check("t6_rx_data", data, 8'h81);
    check("t6_rx_ferr", framing_error, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
